mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage sitting directly downstream of the EX stage. It takes the ALU result as either a load/store address or a pass-through value and performs byte/halfword/word loads and stores over a single-outstanding request/ready data bus. It aligns and sign- or zero-extends load data and registers the result for WB. It stalls upstream while a bus transaction is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, data-bus address width.

Ports (clock and reset first):
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ex_valid`  in  1  EX presents an instruction.
- `ex_result`  in  32  ALU result; this is the address for memory ops.
- `ex_store_data`  in  32  rs2 value for stores.
- `ex_funct3`  in  3  access size/sign: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB/SH/SW use 0/1/2.
- `ex_mem_read`, `ex_mem_write`  in  1  load / store; never both high.
- `ex_rd`  in  5  destination register.
- `ex_reg_write`  in  1  writes rd.
- `mem_stall`  out  1  EX must hold its outputs.
- `dbus_req`  out  1  bus request.
- `dbus_we`  out  1  1 = store.
- `dbus_addr`  out  ADDR_W  word-aligned address, with `[1:0]`=0.
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_wstrb`  out  4  byte enables.
- `dbus_ready`  in  1  transaction complete; `dbus_rdata` valid this cycle.
- `dbus_rdata`  in  32  read word.
- `wb_valid`  out  1  one-cycle result pulse.
- `wb_result`  out  32  load data or pass-through `ex_result`.
- `wb_rd`  out  5  destination register.
- `wb_reg_write`  out  1  write enable, qualified by `wb_valid`.
- `mem_misaligned`  out  1  exception pulse; present only when `MEM_MISALIGN_TRAP_EN` is defined.

## Operation
- **FSM states:** IDLE and WAIT.
- **Accept:** an instruction is accepted when `ex_valid` is high in IDLE. `mem_stall` = (state == WAIT).
- **Non-memory op:** no bus activity. `wb_*` is registered from the `ex_*` inputs, and `wb_valid` goes high the next cycle.
- **Memory op on accept:**
  - Register `addr[1:0]`, `funct3`, `rd` and `reg_write`.
  - Drive `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_wdata` and `dbus_wstrb` as registers.
  - Go to WAIT.
- **WAIT:** all `dbus_*` outputs are held stable until `dbus_ready`. On the `dbus_ready` cycle: `dbus_req` goes to 0 next cycle, `wb_valid` goes to 1 next cycle, and the FSM returns to IDLE.
- **Store lanes:**
  - SB: wstrb = 0001 shifted left by `addr[1:0]`; wdata = {4{sd[7:0]}}.
  - SH: wstrb = 0011 shifted left by `addr[1]`×2; wdata = {2{sd[15:0]}}.
  - SW: wstrb = 1111; wdata = sd.
- **Load extract:** select the byte or halfword at `addr[1:0]` from `dbus_rdata`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- **Store writeback:** stores complete with `wb_valid` = 1 and `wb_reg_write` = 0.
- **`dbus_ready` outside WAIT:** ignored.
- **Reset:** asserting `rst_n` low mid-transaction forces IDLE and drops `dbus_req` immediately and asynchronously. A pending `dbus_ready` after reset is ignored.
- **Reset values:** FSM = IDLE; every output = 0, including `dbus_addr`, `dbus_wdata`, `dbus_wstrb`, `wb_result` and `wb_rd`.

## Timing
- **Non-memory latency:** 1 cycle (accept in cycle N, `wb_valid` in N+1).
- **Memory latency:**
  - Accept in cycle N; `dbus_req` high from N+1.
  - `dbus_ready` in cycle M ≥ N+1; `wb_valid` in M+1.
  - `mem_stall` is high for cycles N+1 through M.
- **Zero-wait bus** (`dbus_ready` in N+1): 2-cycle latency. The next instruction is accepted in N+2.
- **`wb_valid`:** a one-cycle pulse, never high two cycles for one instruction.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned means LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]` ≠ 0.
  - A misaligned access issues no bus request. It pulses `mem_misaligned` and `wb_valid` one cycle after accept, with `wb_reg_write` = 0.
- Not defined:
  - The port is absent.
  - Halfword offset uses `addr[1]` only; word access ignores `addr[1:0]`.

## Structure
- **Shared `define.v`:** `MEM_LB`/`LH`/`LW`/`LBU`/`LHU`/`SB`/`SH`/`SW` funct3 constants and the FSM state encodings.
- **Sub-module `load_align`:** combinational; inputs `rdata`, `offset[1:0]` and `funct3`; output the extended 32-bit value.

## Test plan
- **ALU pass-through:** `ex_result` = 0x0000_1234 with `reg_write` = 1 and no mem op → next cycle `wb_valid` = 1, `wb_result` = 0x1234, with no `dbus_req` ever.
- **LB sign-extend:**
  - Stimulus: LB at 0x103 with `rdata` = 0x80FF_0000 and ready after 3 wait cycles.
  - Bus: `dbus_addr` = 0x100.
  - Result: `wb_result` = 0xFFFF_FF80.
  - Stall: `mem_stall` high for exactly 3 cycles (N+1 through M); the held instruction is not re-accepted.
- **LHU:** at 0x202 with `rdata` = 0xBEEF_1234 → `wb_result` = 0x0000_BEEF.
- **SB:** at 0x301 with `sd` = 0xAABB_CCDD → `wstrb` = 0010, `wdata` = 0xDDDD_DDDD, `dbus_we` = 1, `wb_reg_write` = 0.
- **Zero-wait back-to-back loads:** LW, LW with ready immediate → `wb_valid` at N+2 and N+4.
- **Reset mid-WAIT:** `rst_n` low → `dbus_req` = 0 immediately and all outputs 0. A late `dbus_ready` produces no `wb_valid`.
- **Misaligned LW** (`MEM_MISALIGN_TRAP_EN` defined): LW at 0x102 → no `dbus_req`, `mem_misaligned` pulses at N+1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and helpers for the memory-access stage.
//   - funct3 encodings for loads/stores
//   - FSM state encoding
//   - store lane builder (byte enables + lane-replicated write data)
//   - misalignment predicate (used when MEM_MISALIGN_TRAP_EN is defined)
package mem_stage_pkg;

  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LH  = 3'd1;
  localparam logic [2:0] MEM_LW  = 3'd2;
  localparam logic [2:0] MEM_LBU = 3'd4;
  localparam logic [2:0] MEM_LHU = 3'd5;
  localparam logic [2:0] MEM_SB  = 3'd0;
  localparam logic [2:0] MEM_SH  = 3'd1;
  localparam logic [2:0] MEM_SW  = 3'd2;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [NUM_LANES-1:0]             wstrb;
    logic [NUM_LANES-1:0][LANE_W-1:0] wdata;
  } st_lanes_t;

  // Byte enables follow the address offset; data is replicated across lanes
  // so the bus can take whichever lanes the strobes select.
  function automatic st_lanes_t store_lanes(input logic [2:0]  funct3,
                                            input logic [1:0]  off,
                                            input logic [31:0] sd);
    st_lanes_t r;
    case (funct3)
      MEM_SB: begin
        r.wstrb = 4'b0001 << off;
        r.wdata = {4{sd[7:0]}};
      end
      MEM_SH: begin
        r.wstrb = 4'b0011 << {off[1], 1'b0};
        r.wdata = {2{sd[15:0]}};
      end
      default: begin
        r.wstrb = 4'b1111;
        r.wdata = sd;
      end
    endcase
    return r;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0 (loads and stores alike).
  function automatic logic misaligned(input logic [2:0] funct3,
                                      input logic [1:0] off);
    case (funct3)
      MEM_LH, MEM_LHU: return off[0];
      MEM_LW:          return off != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load data aligner.
//   rdata  : raw bus word
//   offset : byte offset of the access (addr[1:0])
//   funct3 : access size/sign (LB/LH/LW/LBU/LHU)
//   data   : extracted, sign- or zero-extended result
// Halfwords are selected by offset[1] only.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
  logic [7:0]  b;
  logic [15:0] h;

  assign lanes = rdata;
  assign b     = lanes[offset];
  assign h     = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      MEM_LB:  data = {{24{b[7]}}, b};
      MEM_LH:  data = {{16{h[15]}}, h};
      MEM_LBU: data = {24'd0, b};
      MEM_LHU: data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage behind EX.
//   EX side  : ex_valid/ex_result/ex_store_data/ex_funct3/ex_mem_read/
//              ex_mem_write/ex_rd/ex_reg_write in, mem_stall out
//   Bus side : dbus_req/we/addr/wdata/wstrb out (registered, held until
//              dbus_ready), dbus_ready/dbus_rdata in; one transaction at a time
//   WB side  : wb_valid one-cycle pulse with wb_result/wb_rd/wb_reg_write
// Optional: MEM_MISALIGN_TRAP_EN adds mem_misaligned; misaligned accesses then
// skip the bus and complete next cycle with wb_reg_write=0.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  output logic              mem_stall,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  output logic [3:0]        dbus_wstrb,
  input  logic              dbus_ready,
  input  logic [31:0]       dbus_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_result,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              mem_misaligned
`endif
);

  state_e      state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        rw_q;
  logic        is_mem;
  logic        mis;
  logic [31:0] ld_data;
  st_lanes_t   lanes;

  assign is_mem    = ex_mem_read | ex_mem_write;
  assign mem_stall = (state == ST_WAIT);
  assign lanes     = store_lanes(ex_funct3, ex_result[1:0], ex_store_data);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = is_mem & misaligned(ex_funct3, ex_result[1:0]);
`else
  assign mis = 1'b0;
`endif

  load_align u_align (
    .rdata  (dbus_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      off_q        <= '0;
      f3_q         <= '0;
      rw_q         <= 1'b0;
      dbus_req     <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_addr    <= '0;
      dbus_wdata   <= '0;
      dbus_wstrb   <= '0;
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misaligned <= 1'b0;
`endif
    end else begin
      // Result strobes default low so every completion is a single pulse.
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misaligned <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            wb_rd <= ex_rd;
            if (is_mem && !mis) begin
              off_q      <= ex_result[1:0];
              f3_q       <= ex_funct3;
              rw_q       <= ex_reg_write & ex_mem_read;
              dbus_req   <= 1'b1;
              dbus_we    <= ex_mem_write;
              dbus_addr  <= {ex_result[ADDR_W-1:2], 2'b00};
              dbus_wdata <= lanes.wdata;
              dbus_wstrb <= ex_mem_write ? lanes.wstrb : 4'b0000;
              state      <= ST_WAIT;
            end else begin
              // ALU pass-through, or a trapped access reporting its address.
              wb_valid     <= 1'b1;
              wb_result    <= ex_result;
              wb_reg_write <= ex_reg_write & ~mis;
`ifdef MEM_MISALIGN_TRAP_EN
              mem_misaligned <= mis;
`endif
            end
          end
        end
        ST_WAIT: begin
          if (dbus_ready) begin
            dbus_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_result    <= dbus_we ? 32'd0 : ld_data;
            wb_reg_write <= rw_q;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage with a
// transaction-level reference model (byte arithmetic on the bus word).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        mem_stall;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ready = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misaligned;
`endif

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_funct3     (ex_funct3),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_stall     (mem_stall),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_wdata    (dbus_wdata),
    .dbus_wstrb    (dbus_wstrb),
    .dbus_ready    (dbus_ready),
    .dbus_rdata    (dbus_rdata),
    .wb_valid      (wb_valid),
    .wb_result     (wb_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .mem_misaligned(mem_misaligned)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    logic [31:0] v;
    logic [1:0]  o;
    o = a[1:0];
    case (f3)
      3'd0, 3'd4: begin
        v = (rdata >> (8 * o)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (rdata >> (16 * o[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [1:0] o;
    o = a[1:0];
    if (f3 == 3'd0) return 32'(1 << o);
    if (f3 == 3'd1) return 32'(3 << (2 * o[1]));
    return 32'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 3'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic bit m_mis(input bit mem, input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (!mem) return 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Expected writeback of the previous instruction, checked at the next negedge.
  bit          exp_pending = 0;
  bit          exp_chk_res = 0;
  bit          exp_mis = 0;
  logic [31:0] exp_result = '0;
  logic [4:0]  exp_rd = '0;
  logic        exp_rw = 1'b0;

  task automatic check_wb();
    chk("stall_idle", mem_stall, 0);
    chk("req_idle", dbus_req, 0);
    if (exp_pending) begin
      chk("wb_valid", wb_valid, 1);
      chk("wb_rd", wb_rd, exp_rd);
      chk("wb_reg_write", wb_reg_write, exp_rw);
      if (exp_chk_res) chk("wb_result", wb_result, exp_result);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mem_misaligned", mem_misaligned, exp_mis);
`endif
    end else begin
      chk("wb_idle", wb_valid, 0);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mis_idle", mem_misaligned, 0);
`endif
    end
    exp_pending = 0;
  endtask

  // Entered and left at a negedge. Memory ops hold ex_valid through the stall.
  task automatic do_op(input bit rd_op, input bit wr_op, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input bit rw, input int lat,
                       input logic [31:0] rdata);
    bit mem, mis;
    check_wb();
    ex_valid = 1; ex_result = res; ex_store_data = sd; ex_funct3 = f3;
    ex_mem_read = rd_op; ex_mem_write = wr_op; ex_rd = rd; ex_reg_write = rw;
    @(posedge clk); @(negedge clk);
    mem = rd_op | wr_op;
    mis = m_mis(mem, f3, res);
    if (!mem || mis) begin
      ex_valid = 0;
      chk("nomem_req", dbus_req, 0);
      exp_pending = 1; exp_result = res; exp_rd = rd;
      exp_rw = rw && !mis; exp_chk_res = !mis; exp_mis = mis;
    end else begin
      for (int k = 1; k <= lat; k++) begin
        if (k > 1) begin @(posedge clk); @(negedge clk); end
        chk("stall_wait", mem_stall, 1);
        chk("req_wait", dbus_req, 1);
        chk("dbus_we", dbus_we, wr_op);
        chk("dbus_addr", dbus_addr, res & 32'hFFFF_FFFC);
        if (wr_op) begin
          chk("dbus_wstrb", dbus_wstrb, m_strb(f3, res));
          chk("dbus_wdata", dbus_wdata, m_wdata(f3, sd));
        end
        chk("wb_in_wait", wb_valid, 0);
        if (k == lat) begin
          dbus_ready = 1; dbus_rdata = rdata; ex_valid = 0;
        end
      end
      @(posedge clk); @(negedge clk);
      dbus_ready = 0; dbus_rdata = $urandom;
      exp_pending = 1; exp_rd = rd; exp_rw = rw && rd_op;
      exp_chk_res = rd_op; exp_mis = 0;
      exp_result = m_load(f3, res, rdata);
    end
  endtask

  // Idle cycles; a stray dbus_ready here must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      check_wb();
      ex_valid = 0;
      dbus_ready = 1'($urandom_range(0, 1));
      dbus_rdata = $urandom;
      @(posedge clk); @(negedge clk);
      dbus_ready = 0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, mem_stall, 0);
    chk({tag, "_req"}, dbus_req, 0);
    chk({tag, "_we"}, dbus_we, 0);
    chk({tag, "_addr"}, dbus_addr, 0);
    chk({tag, "_wdata"}, dbus_wdata, 0);
    chk({tag, "_wstrb"}, dbus_wstrb, 0);
    chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_wbres"}, wb_result, 0);
    chk({tag, "_wbrd"}, wb_rd, 0);
    chk({tag, "_wbrw"}, wb_reg_write, 0);
  endtask

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    // reset state
    #12;
    chk_all_zero("rst");
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // ALU pass-through, then single-pulse check
    do_op(0, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd3, 1, 1, 32'h0);
    exp_result = 32'h0000_1234;
    idle(2);

    // LB sign-extend, 3 stall cycles
    do_op(1, 0, 3'd0, 32'h0000_0103, 32'h0, 5'd7, 1, 3, 32'h80FF_0000);
    exp_result = 32'hFFFF_FF80;
    idle(1);

    // LHU
    do_op(1, 0, 3'd5, 32'h0000_0202, 32'h0, 5'd8, 1, 2, 32'hBEEF_1234);
    exp_result = 32'h0000_BEEF;
    idle(1);

    // SB lanes
    do_op(0, 1, 3'd0, 32'h0000_0301, 32'hAABB_CCDD, 5'd9, 1, 1, 32'h0);
    chk("sb_wb_rw_exp", {31'd0, exp_rw}, 0);
    idle(1);

    // zero-wait back-to-back loads
    do_op(1, 0, 3'd2, 32'h0000_0400, 32'h0, 5'd10, 1, 1, 32'h1111_2222);
    do_op(1, 0, 3'd2, 32'h0000_0404, 32'h0, 5'd11, 1, 1, 32'h3333_4444);
    idle(2);

`ifdef MEM_MISALIGN_TRAP_EN
    do_op(1, 0, 3'd2, 32'h0000_0102, 32'h0, 5'd12, 1, 1, 32'h0);
    idle(1);
`endif

    // reset mid-WAIT, then late ready
    check_wb();
    ex_valid = 1; ex_result = 32'h0000_0500; ex_funct3 = 3'd2;
    ex_mem_read = 1; ex_mem_write = 0; ex_rd = 5'd13; ex_reg_write = 1;
    @(posedge clk); @(negedge clk);
    chk("rstw_req_before", dbus_req, 1);
    #2 rst_n = 0;
    #1 chk_all_zero("rstw");
    ex_valid = 0; dbus_ready = 1;
    @(negedge clk); rst_n = 1;
    @(posedge clk); @(negedge clk);
    chk("rstw_late_ready_wb", wb_valid, 0);
    chk("rstw_late_ready_req", dbus_req, 0);
    dbus_ready = 0;
    exp_pending = 0;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        do_op(0, 0, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
              1'($urandom_range(0, 1)), 1, 32'h0);
      end else if (kind < 7) begin
        f3 = ld_f3[$urandom_range(0, 4)];
        do_op(1, 0, f3, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(1, 4), $urandom);
      end else if (kind < 9) begin
        f3 = 3'($urandom_range(0, 2));
        do_op(0, 1, f3, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(1, 4), $urandom);
      end else begin
        idle($urandom_range(1, 2));
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
